// File: rtl/lif_multi_channel_system_if.sv
// Pin bundle for the multi-channel LIF core: control, channel inputs, serial config and neuron outputs.
interface lif_multi_channel_system_if #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 6,
  parameter int V_W    = 8
);
  logic                   enable;
  logic                   input_enable;
  logic [NUM_CH*IN_W-1:0] chan_in;
  logic                   load_mode;
  logic                   serial_data;
  logic                   spike_out;
  logic [V_W-1:0]         v_mem_out;
  logic                   params_ready;
  logic [7:0]             spike_cnt;

  modport master (
    output enable, input_enable, chan_in, load_mode, serial_data,
    input  spike_out, v_mem_out, params_ready, spike_cnt
  );

  modport slave (
    input  enable, input_enable, chan_in, load_mode, serial_data,
    output spike_out, v_mem_out, params_ready, spike_cnt
  );
endinterface

// File: rtl/lif_multi_channel_system.sv
// Multi-channel leaky integrate-and-fire neuron with serially loaded weights/threshold/leak/refractory period.
// Optional spike counter enabled by defining LIF_SPIKE_CNT_EN.
module lif_multi_channel_system #(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 6,
  parameter int W_W    = 3,
  parameter int V_W    = 8,
  parameter int REF_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lif_multi_channel_system_if.slave    bus
);

  localparam int CFG_BITS = NUM_CH*W_W + 2*V_W + REF_W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam int SUM_W    = IN_W + W_W + $clog2(NUM_CH + 1);
  localparam int ACC_W    = ((SUM_W > V_W) ? SUM_W : V_W) + 2;
  localparam int LEAK_LSB = REF_W;
  localparam int THR_LSB  = V_W + REF_W;
  localparam int W_LSB    = 2*V_W + REF_W;

  typedef enum logic [1:0] {
    ST_CFG,
    ST_RUN,
    ST_REFRACT
  } state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] act_q, act_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [V_W-1:0]      v_q, v_d;
  logic                spike_q, spike_d;
  logic [REF_W-1:0]    ref_q, ref_d;

  logic [V_W-1:0]      thr;
  logic [V_W-1:0]      leak;
  logic [REF_W-1:0]    refrac;
  logic [SUM_W-1:0]    sum;
  logic signed [ACC_W-1:0] acc;
  logic [V_W-1:0]      v_clamp;

  assign thr    = act_q[THR_LSB +: V_W];
  assign leak   = act_q[LEAK_LSB +: V_W];
  assign refrac = act_q[REF_W-1:0];

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(bus.chan_in[i*IN_W +: IN_W]) * SUM_W'(act_q[W_LSB + i*W_W +: W_W]);
    end
  end

  // Widened signed accumulator so both underflow and overflow are visible before clamping.
  assign acc = $signed(ACC_W'(v_q)) + $signed(ACC_W'(sum)) - $signed(ACC_W'(leak));

  always_comb begin
    if (acc[ACC_W-1]) begin
      v_clamp = '0;
    end else if (|acc[ACC_W-2:V_W]) begin
      v_clamp = '1;
    end else begin
      v_clamp = acc[V_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    act_d     = act_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    v_d       = v_q;
    spike_d   = 1'b0;
    ref_d     = ref_q;

    if (bus.load_mode) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], bus.serial_data};
      if (bit_cnt_q != CNT_W'(CFG_BITS)) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      ready_d = 1'b0;
      v_d     = '0;
      ref_d   = '0;
      state_d = ST_CFG;
    end else if (bit_cnt_q != '0) begin
      // A non-zero bit count marks the first idle cycle after a load: close the frame here.
      if (bit_cnt_q == CNT_W'(CFG_BITS)) begin
        act_d   = shadow_q;
        valid_d = 1'b1;
      end
      bit_cnt_d = '0;
      ready_d   = 1'b0;
    end else begin
      ready_d = valid_q;
      unique case (state_q)
        ST_CFG: begin
          if (valid_q) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.input_enable) begin
            if (v_clamp >= thr) begin
              spike_d = 1'b1;
              v_d     = '0;
              if (refrac != '0) begin
                ref_d   = refrac;
                state_d = ST_REFRACT;
              end
            end else begin
              v_d = v_clamp;
            end
          end
        end
        ST_REFRACT: begin
          v_d   = '0;
          ref_d = ref_q - REF_W'(1);
          if (ref_q <= REF_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_CFG;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CFG;
      shadow_q  <= '0;
      act_q     <= '0;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      v_q       <= '0;
      spike_q   <= 1'b0;
      ref_q     <= '0;
    end else if (bus.enable) begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      act_q     <= act_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      v_q       <= v_d;
      spike_q   <= spike_d;
      ref_q     <= ref_d;
    end
  end

  assign bus.spike_out    = spike_q;
  assign bus.v_mem_out    = v_q;
  assign bus.params_ready = ready_q;

`ifdef LIF_SPIKE_CNT_EN
  logic       commit;
  logic [7:0] scnt_q;

  assign commit = !bus.load_mode && (bit_cnt_q == CNT_W'(CFG_BITS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt_q <= '0;
    end else if (bus.enable) begin
      if (commit) begin
        scnt_q <= '0;
      end else if (spike_d && (scnt_q != 8'hFF)) begin
        scnt_q <= scnt_q + 8'd1;
      end
    end
  end

  assign bus.spike_cnt = scnt_q;
`else
  assign bus.spike_cnt = '0;
`endif

endmodule
